// File: rtl/oscill_nios_niosii_cpu_mul_pkg.sv
`default_nettype none
// =============================================================================
// Module : oscill_nios_niosii_cpu_mul_pkg
// Brief  : Op encodings, sequencer states and partial-product shift table for
//          the single-cell 32x32 multiply sequencer.
// Rev    : 1.0 - initial release
// =============================================================================
package oscill_nios_niosii_cpu_mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
    localparam logic [1:0] MUL_OP_MULXSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULXSS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mul_state_e;

    // Element k is the accumulator shift for partial-product pair k.
    localparam logic [3:0][5:0] PAIR_SHIFT = {6'd32, 6'd16, 6'd16, 6'd0};

    function automatic logic [63:0] pair_addend(input logic [1:0] idx, input logic [31:0] prod);
        return {32'h0, prod} << PAIR_SHIFT[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/oscill_nios_niosii_cpu_mul_tagpipe.sv
`default_nettype none
// =============================================================================
// Module : oscill_nios_niosii_cpu_mul_tagpipe
// Brief  : DEPTH-deep {valid, idx} shift register tracking products in flight
//          through the external multiplier cell; enable and synchronous clear.
// Rev    : 1.0 - initial release
// =============================================================================
module oscill_nios_niosii_cpu_mul_tagpipe #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [1:0] in_idx,
    output logic       out_valid,
    output logic [1:0] out_idx
);

    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0][1:0] r_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_idx   <= '0;
        end else if (clr) begin
            r_valid <= '0;
        end else if (en) begin
            r_valid[0] <= in_valid;
            r_idx[0]   <= in_idx;
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_idx   = r_idx[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/oscill_nios_niosii_cpu_mul_seq.sv
`default_nettype none
// =============================================================================
// Module : oscill_nios_niosii_cpu_mul_seq
// Brief  : Drives one external 16x16 registered multiplier cell through 3 or 4
//          partial products and returns the 32-bit MUL / MULX* result.
// Rev    : 1.0 - initial release
// =============================================================================
module oscill_nios_niosii_cpu_mul_seq
    import oscill_nios_niosii_cpu_mul_pkg::*;
#(
    parameter int MUL_LATENCY = 1,
    parameter bit MULX_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        kill,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        mul_en,
    input  logic [31:0] mul_p,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        busy
);

    localparam logic [1:0] c_drain_last = 2'(MUL_LATENCY);

    mul_state_e  r_state;
    mul_state_e  w_state_next;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_idx;
    logic [1:0]  r_last_idx;
    logic [1:0]  r_drain_cnt;
    logic [63:0] r_acc;
    logic [15:0] r_mul_a;
    logic [15:0] r_mul_b;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_tag_valid;
    logic [1:0]  w_tag_idx;
    logic        w_acc_fire;
    logic [1:0]  w_idx_next;
    logic [31:0] w_corr_a;
    logic [31:0] w_corr_b;
    logic [31:0] w_result;

    assign w_accept   = (r_state == ST_IDLE) && req_valid && !kill;
    // The final DRAIN cycle keeps the cell frozen while the last product settles
    // into the accumulator, so the result is formed from a stable register.
    assign mul_en     = ((r_state == ST_ISSUE) ||
                         ((r_state == ST_DRAIN) && (r_drain_cnt != c_drain_last))) && !kill;
    assign w_acc_fire = w_tag_valid && mul_en;
    assign w_idx_next = r_idx + 2'd1;

    oscill_nios_niosii_cpu_mul_tagpipe #(
        .DEPTH (MUL_LATENCY)
    ) u_tagpipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (mul_en),
        .clr       (kill),
        .in_valid  (r_state == ST_ISSUE),
        .in_idx    (r_idx),
        .out_valid (w_tag_valid),
        .out_idx   (w_tag_idx)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_ISSUE;
            ST_ISSUE: if (r_idx == r_last_idx) w_state_next = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == c_drain_last) w_state_next = ST_DONE;
            ST_DONE:  if (rsp_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        if (kill) w_state_next = ST_IDLE;
    end

    // Unsigned high word corrected for operands treated as two's complement.
    always_comb begin
        w_corr_a = '0;
        w_corr_b = '0;
        if (r_a[31] && ((r_op == MUL_OP_MULXSU) || (r_op == MUL_OP_MULXSS))) w_corr_a = r_b;
        if (r_b[31] && (r_op == MUL_OP_MULXSS)) w_corr_b = r_a;
        if (r_op == MUL_OP_MUL)  w_result = r_acc[31:0];
        else if (MULX_EN)        w_result = r_acc[63:32] - w_corr_a - w_corr_b;
        else                     w_result = 32'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_op        <= MUL_OP_MUL;
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_last_idx  <= '0;
            r_drain_cnt <= '0;
            r_acc       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_result    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op        <= req_op;
                r_a         <= req_src1;
                r_b         <= req_src2;
                r_acc       <= '0;
                r_idx       <= '0;
                r_drain_cnt <= '0;
                r_last_idx  <= ((req_op == MUL_OP_MUL) || !MULX_EN) ? 2'd2 : 2'd3;
                r_mul_a     <= req_src1[15:0];
                r_mul_b     <= req_src2[15:0];
            end else begin
                if (w_acc_fire) r_acc <= r_acc + pair_addend(w_tag_idx, mul_p);
                if ((r_state == ST_ISSUE) && !kill && (r_idx != r_last_idx)) begin
                    r_idx   <= w_idx_next;
                    r_mul_a <= w_idx_next[1] ? r_a[31:16] : r_a[15:0];
                    r_mul_b <= w_idx_next[0] ? r_b[31:16] : r_b[15:0];
                end
                if ((r_state == ST_DRAIN) && !kill && (r_drain_cnt != c_drain_last))
                    r_drain_cnt <= r_drain_cnt + 2'd1;
                if ((r_state == ST_DRAIN) && (w_state_next == ST_DONE))
                    r_result <= w_result;
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign rsp_valid  = (r_state == ST_DONE) && !kill;
    assign rsp_result = r_result;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;

endmodule
`default_nettype wire
